// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default threshold constants for the ring FIFO slice.
package fifo_pkg;

    localparam int AEMPTY_TH_DEF    = 1;
    // The default almost-full threshold is DEPTH minus this margin.
    localparam int AFULL_MARGIN_DEF = 1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ring_fifo_if.sv
// Push/pop and status bundle for ring_fifo.
// The overflow/underflow flags exist only when RING_FIFO_ERR_FLAGS_EN is defined.
interface ring_fifo_if import fifo_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic                      write;
    logic [DATA_W-1:0]         in;
    logic                      read;
    logic [DATA_W-1:0]         out;
    logic                      val;
    logic                      full;
    logic                      empty;
    logic                      afull;
    logic                      aempty;
    logic [cnt_w(DEPTH)-1:0]   count;
`ifdef RING_FIFO_ERR_FLAGS_EN
    logic                      overflow;
    logic                      underflow;
`endif

`ifdef RING_FIFO_ERR_FLAGS_EN
    modport master (output write, in, read,
                    input  out, val, full, empty, afull, aempty, count, overflow, underflow);
    modport slave  (input  write, in, read,
                    output out, val, full, empty, afull, aempty, count, overflow, underflow);
`else
    modport master (output write, in, read,
                    input  out, val, full, empty, afull, aempty, count);
    modport slave  (input  write, in, read,
                    output out, val, full, empty, afull, aempty, count);
`endif

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read. No reset on contents.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with registered pop data, occupancy count and threshold flags.
// Optional sticky overflow/underflow flags under RING_FIFO_ERR_FLAGS_EN.
module ring_fifo import fifo_pkg::*; #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - AFULL_MARGIN_DEF,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    ring_fifo_if.slave  bus
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    if (DEPTH < 2 || AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad_params
        $error("ring_fifo: illegal parameters DEPTH=%0d AFULL_TH=%0d AEMPTY_TH=%0d",
               DEPTH, AFULL_TH, AEMPTY_TH);
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] out_q;
    logic              val_q;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic              rd_ok;
    logic              wr_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // A full FIFO still accepts a write when a pop frees the slot on the same edge.
    assign rd_ok = bus.read & ~empty;
    assign wr_ok = bus.write & (~full | rd_ok);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we      (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (bus.in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            out_q  <= '0;
            val_q  <= 1'b0;
        end else begin
            val_q <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
                out_q  <= rd_data;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RING_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.write & ~wr_ok) overflow_q  <= 1'b1;
            if (bus.read & empty)   underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

    assign bus.out    = out_q;
    assign bus.val    = val_q;
    assign bus.count  = count;
    assign bus.full   = full;
    assign bus.empty  = empty;
    assign bus.afull  = (count >= CNT_W'(AFULL_TH));
    assign bus.aempty = (count <= CNT_W'(AEMPTY_TH));

endmodule

// File: tb/tb_ring_fifo.sv
// Directed bench for ring_fifo at DATA_W=8, DEPTH=5, AFULL_TH=4, AEMPTY_TH=1.
module tb_ring_fifo;

    typedef struct {
        string    name;
        bit       r;
        bit       w;
        bit       rd;
        bit [7:0] din;
        bit [7:0] eout;
        bit       eval;
        int       ecnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ring_fifo_if #(.DATA_W(8), .DEPTH(5)) bus ();

    ring_fifo #(
        .DATA_W    (8),
        .DEPTH     (5),
        .AFULL_TH  (4),
        .AEMPTY_TH (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Flags are checked against literal thresholds: full=5, empty=0, afull>=4, aempty<=1.
    task automatic chk_state(input string name, input bit [7:0] eout, input bit eval, input int ecnt);
        chk({name, ".out"},    32'(bus.out),    32'(eout));
        chk({name, ".val"},    32'(bus.val),    32'(eval));
        chk({name, ".count"},  32'(bus.count),  32'(ecnt));
        chk({name, ".full"},   32'(bus.full),   32'(ecnt == 5));
        chk({name, ".empty"},  32'(bus.empty),  32'(ecnt == 0));
        chk({name, ".afull"},  32'(bus.afull),  32'(ecnt >= 4));
        chk({name, ".aempty"}, 32'(bus.aempty), 32'(ecnt <= 1));
    endtask

    task automatic apply(input bit r, input bit w, input bit rd, input bit [7:0] d);
        @(negedge clk);
        rst       = r;
        bus.write = w;
        bus.read  = rd;
        bus.in    = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input string name, input bit r, input bit w, input bit rd,
                                input bit [7:0] din, input bit [7:0] eout, input bit eval,
                                input int ecnt);
        vec_t v;
        v.name = name; v.r = r; v.w = w; v.rd = rd; v.din = din;
        v.eout = eout; v.eval = eval; v.ecnt = ecnt;
        vecs.push_back(v);
    endfunction

    initial begin
        bus.write = 1'b0;
        bus.read  = 1'b0;
        bus.in    = '0;

        add("reset", 1, 0, 0, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) add("fill", 0, 1, 0, 8'(8'h11 + i), 8'h00, 0, i + 1);
        for (int i = 0; i < 5; i++) add("drain", 0, 0, 1, 8'h00, 8'(8'h11 + i), 1, 4 - i);
        add("rd_empty", 0, 0, 1, 8'h00, 8'h15, 0, 0);
        add("wr_rd_empty", 0, 1, 1, 8'h55, 8'h15, 0, 1);
        add("rd_55", 0, 0, 1, 8'h00, 8'h55, 1, 0);
        for (int i = 0; i < 5; i++) add("fill_a", 0, 1, 0, 8'(8'hA0 + i), 8'h55, 0, i + 1);
        add("wr_rd_full", 0, 1, 1, 8'hB0, 8'hA0, 1, 5);
        add("wr_full_drop", 0, 1, 0, 8'hC0, 8'hA0, 0, 5);
        for (int i = 0; i < 4; i++) add("drain_a", 0, 0, 1, 8'h00, 8'(8'hA1 + i), 1, 4 - i);
        add("drain_b0", 0, 0, 1, 8'h00, 8'hB0, 1, 0);
        for (int i = 0; i < 3; i++) add("pre_rst", 0, 1, 0, 8'(i + 1), 8'hB0, 0, i + 1);
        add("rst_busy", 1, 1, 1, 8'h99, 8'h00, 0, 0);
        add("wr_77", 0, 1, 0, 8'h77, 8'h00, 0, 1);
        add("rd_77", 0, 0, 1, 8'h00, 8'h77, 1, 0);

        foreach (vecs[k]) begin
            apply(vecs[k].r, vecs[k].w, vecs[k].rd, vecs[k].din);
            chk_state(vecs[k].name, vecs[k].eout, vecs[k].eval, vecs[k].ecnt);
        end

        // Thirteen write-then-read pairs walk both pointers around the ring several times.
        for (int i = 0; i < 13; i++) begin
            apply(0, 1, 0, 8'(i));
            chk_state("wrap_wr", 8'(i == 0 ? 8'h77 : i - 1), 0, 1);
            apply(0, 0, 1, 8'h00);
            chk_state("wrap_rd", 8'(i), 1, 0);
        end

        // Back-to-back streaming: write on one edge, pop it on the next while writing again.
        apply(0, 1, 0, 8'h40);
        chk_state("stream_w0", 8'h0C, 0, 1);
        for (int i = 1; i < 4; i++) begin
            apply(0, 1, 1, 8'(8'h40 + i));
            chk_state("stream", 8'(8'h40 + i - 1), 1, 1);
        end
        apply(0, 0, 1, 8'h00);
        chk_state("stream_end", 8'h43, 1, 0);

`ifdef RING_FIFO_ERR_FLAGS_EN
        apply(1, 0, 0, 8'h00);
        chk("err_rst.overflow",  32'(bus.overflow),  32'd0);
        chk("err_rst.underflow", 32'(bus.underflow), 32'd0);
        for (int i = 0; i < 5; i++) apply(0, 1, 0, 8'(8'hD0 + i));
        chk("err_full.overflow", 32'(bus.overflow), 32'd0);
        apply(0, 1, 0, 8'hEE);
        chk_state("err_drop", 8'h00, 0, 5);
        chk("err_ovf.overflow",  32'(bus.overflow),  32'd1);
        chk("err_ovf.underflow", 32'(bus.underflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 8'h00);
            chk("err_data", 32'(bus.out), 32'(8'hD0 + i));
        end
        apply(0, 0, 1, 8'h00);
        chk("err_unf.underflow", 32'(bus.underflow), 32'd1);
        chk("err_unf.overflow",  32'(bus.overflow),  32'd1);
        chk("err_unf.val",       32'(bus.val),       32'd0);
        apply(0, 1, 0, 8'h12);
        apply(0, 0, 1, 8'h00);
        chk("err_hold.overflow",  32'(bus.overflow),  32'd1);
        chk("err_hold.underflow", 32'(bus.underflow), 32'd1);
        apply(1, 0, 0, 8'h00);
        chk("err_clr.overflow",  32'(bus.overflow),  32'd0);
        chk("err_clr.underflow", 32'(bus.underflow), 32'd0);
`endif

        @(negedge clk);
        bus.write = 1'b0;
        bus.read  = 1'b0;
        rst       = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
